// File: rtl/ram_dump_streamer.sv
// Post-halt RAM window dumper: borrows the RAM read port from the arbiter and
// streams each byte of [start_addr..end_addr] (wrapping) over valid/ready.
module ram_dump_streamer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  halt,
  output logic                  ram_req,
  input  logic                  ram_gnt,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_READ    = 3'd2,
    S_WAIT    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [1:0]          LAT_LAST = 2'(RAM_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [1:0]              lat_q, lat_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   span;

  // Window length minus one, modulo the address space, so end < start wraps.
  assign span = end_addr - start_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      hold_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  // Stream handshake: a byte transfers on a rising edge where out_valid and
  // out_ready are both high; once raised, out_valid and its payload
  // (out_data/out_addr/out_last) hold until that transfer, and out_ready may
  // toggle freely.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    hold_d  = hold_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!halt) begin
            err_d = 1'b1;
          end else begin
            addr_d  = start_addr;
            count_d = {1'b0, span} + CNT_ONE;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (ram_gnt) state_d = S_READ;
      end
      S_READ: begin
        lat_d   = 2'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          hold_d  = ram_rd_data;
          state_d = S_PRESENT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (count_q == CNT_ONE) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            count_d = count_q - CNT_ONE;
            state_d = ram_gnt ? S_READ : S_REQ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_req   = (state_q == S_REQ) || (state_q == S_READ) ||
                     (state_q == S_WAIT) || (state_q == S_PRESENT);
  assign ram_rd_en = (state_q == S_READ);
  assign ram_addr  = addr_q;
  assign out_valid = (state_q == S_PRESENT);
  assign out_data  = hold_q;
  assign out_addr  = addr_q;
  assign out_last  = (state_q == S_PRESENT) && (count_q == CNT_ONE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_dump_streamer.sv
// Self-checking bench for ram_dump_streamer: a behavioural RAM plus a window
// model that lists the expected (addr, data, last) stream for each dump.
module tb_ram_dump_streamer;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int LAT   = 1;
  localparam int W     = AW + DW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk, reset, start, halt;
  logic [AW-1:0] start_addr, end_addr, ram_addr, out_addr;
  logic          ram_req, ram_gnt, ram_rd_en;
  logic [DW-1:0] ram_rd_data, out_data;
  logic          out_valid, out_ready, out_last, busy, done, err;
  logic [2:0]    dbg_state;

  logic [DW-1:0] mem [DEPTH];
  logic [W-1:0]  exp_q[$];
  int            vectors;
  int            miscompares;

  ram_dump_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .halt(halt), .ram_req(ram_req), .ram_gnt(ram_gnt),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-cycle-latency RAM read port.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: window of ((e - s) mod DEPTH) + 1 bytes starting at s.
  function automatic int build_expected(input logic [AW-1:0] s, input logic [AW-1:0] e);
    int n;
    int a;
    exp_q.delete();
    n = ((int'(e) - int'(s) + DEPTH) % DEPTH) + 1;
    for (int i = 0; i < n; i++) begin
      a = (int'(s) + i) % DEPTH;
      exp_q.push_back({AW'(a), mem[a], (i == n - 1)});
    end
    return n;
  endfunction

  // driver tasks
  task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    @(negedge clk);
    start = 1'b1;
    start_addr = s;
    end_addr = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_dump(input string name, input int ready_pct, input int stall_first,
                          input int busy_start_at, input bit drop_gnt, input int n,
                          output int cycles);
    int dones, rd_ens, errs, stall_left, gnt_off;
    bit held, first_done, finished;
    logic [DW-1:0] h_data;
    logic [AW-1:0] h_addr;
    logic [W-1:0]  e;
    dones = 0; rd_ens = 0; errs = 0; gnt_off = 0;
    stall_left = stall_first;
    held = 0; first_done = 0; finished = 0;
    h_data = '0; h_addr = '0; cycles = 0;
    for (int cyc = 1; cyc <= 40 * n + 20 && !finished; cyc++) begin
      @(negedge clk);
      cycles = cyc;
      start = (cyc == busy_start_at);
      if (start) begin
        start_addr = AW'($urandom_range(DEPTH - 1));
        end_addr = start_addr;
      end
      if (ram_rd_en) rd_ens++;
      if (err) errs++;
      vectors++;
      if ((out_valid && ram_rd_en) || (out_last && !out_valid)) begin
        miscompares++;
        $display("FAIL %s overlap: got valid=%0b rd_en=%0b last=%0b, expected no valid with rd_en and no last without valid",
                 name, out_valid, ram_rd_en, out_last);
      end
      if (gnt_off > 0) begin
        vectors++;
        if (ram_rd_en !== 1'b0 || ram_req !== 1'b1) begin
          miscompares++;
          $display("FAIL %s grant_hold: got rd_en=%0b req=%0b, expected rd_en=0 req=1", name, ram_rd_en, ram_req);
        end
        gnt_off--;
        if (gnt_off == 0) ram_gnt = 1'b1;
      end
      if (held) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== h_data || out_addr !== h_addr) begin
          miscompares++;
          $display("FAIL %s stable: got valid=%0b data=%0h addr=%0h, expected valid=1 data=%0h addr=%0h",
                   name, out_valid, out_data, out_addr, h_data, h_addr);
        end
      end
      if (out_valid && !first_done && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      if (out_valid) begin
        if (out_ready) begin
          held = 0;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s extra_byte: got addr=%0h data=%0h, expected no more bytes", name, out_addr, out_data);
          end else begin
            e = exp_q.pop_front();
            if ({out_addr, out_data, out_last} !== e) begin
              miscompares++;
              $display("FAIL %s byte: got addr=%0h data=%0h last=%0b, expected addr=%0h data=%0h last=%0b",
                       name, out_addr, out_data, out_last, e[W-1 -: AW], e[DW:1], e[0]);
            end
          end
          if (!first_done && drop_gnt) begin
            ram_gnt = 1'b0;
            gnt_off = 4;
          end
          first_done = 1;
        end else begin
          held = 1;
          h_data = out_data;
          h_addr = out_addr;
        end
      end
      if (done) begin
        dones++;
        finished = 1;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    ram_gnt = 1'b1;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL %s timeout: got no done after %0d cycles, expected done", name, cycles);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done: got done=%0b busy=%0b, expected done=0 busy=0", name, done, busy);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing: got %0d bytes undelivered, expected 0", name, exp_q.size());
    end
    vectors++;
    if (rd_ens != n) begin
      miscompares++;
      $display("FAIL %s rd_count: got %0d reads, expected %0d", name, rd_ens, n);
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL %s err_during: got %0d err pulses, expected 0", name, errs);
    end
  endtask

  task automatic check_throughput(input string name, input int cycles, input int n);
    vectors++;
    if (cycles > (2 + LAT) * n + 1) begin
      miscompares++;
      $display("FAIL %s throughput: got %0d cycles, expected at most %0d", name, cycles, (2 + LAT) * n + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    halt = 1'b1; ram_gnt = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ram_req, ram_rd_en, out_valid, out_last, busy, done, err} !== 7'b0 ||
        ram_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%0b rd=%0b valid=%0b last=%0b busy=%0b done=%0b err=%0b addr=%0h oaddr=%0h data=%0h, expected all 0",
               ram_req, ram_rd_en, out_valid, out_last, busy, done, err, ram_addr, out_addr, out_data);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ram_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got busy=%0b req=%0b, expected 0 0", busy, ram_req);
    end
  endtask

  task automatic test_basic();
    int n, c;
    mem[14] = 8'h1F;
    mem[15] = 8'hAB;
    n = build_expected(4'd14, 4'd15);
    pulse_start(4'd14, 4'd15);
    run_dump("basic", 100, 0, 0, 1'b0, n, c);
    check_throughput("basic", c, n);
  endtask

  task automatic test_wrap();
    int n, c;
    mem[14] = 8'h10; mem[15] = 8'h11; mem[0] = 8'h12; mem[1] = 8'h13;
    n = build_expected(4'd14, 4'd1);
    pulse_start(4'd14, 4'd1);
    run_dump("wrap", 100, 0, 0, 1'b0, n, c);
    check_throughput("wrap", c, n);
  endtask

  task automatic test_backpressure();
    int n, c;
    for (int i = 0; i < 3; i++) mem[i] = DW'($urandom);
    n = build_expected(4'd0, 4'd2);
    pulse_start(4'd0, 4'd2);
    run_dump("backpressure", 100, 5, 0, 1'b0, n, c);
  endtask

  task automatic test_reject();
    halt = 1'b0;
    pulse_start(4'd2, 4'd5);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || ram_req !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_pulse: got err=%0b busy=%0b req=%0b valid=%0b, expected 1 0 0 0", err, busy, ram_req, out_valid);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0 || ram_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_after: got err=%0b busy=%0b rd=%0b, expected 0 0 0", err, busy, ram_rd_en);
    end
    halt = 1'b1;
  endtask

  task automatic test_busy_start();
    int n, c;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    n = build_expected(4'd5, 4'd7);
    pulse_start(4'd5, 4'd7);
    run_dump("busy_start", 100, 0, 4, 1'b0, n, c);
  endtask

  task automatic test_grant_loss();
    int n, c;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    n = build_expected(4'd9, 4'd11);
    pulse_start(4'd9, 4'd11);
    run_dump("grant_loss", 100, 0, 0, 1'b1, n, c);
  endtask

  task automatic test_reset_mid_dump();
    int n, c, dones;
    bit seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    out_ready = 1'b0;
    pulse_start(4'd3, 4'd8);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_present: got out_valid=0, expected PRESENT reached");
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, ram_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_async: got valid=%0b busy=%0b req=%0b, expected 0 0 0", out_valid, busy, ram_req);
    end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    vectors++;
    if (dones != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_nodone: got dones=%0d busy=%0b, expected 0 0", dones, busy);
    end
    mem[0] = DW'($urandom);
    n = build_expected(4'd0, 4'd0);
    pulse_start(4'd0, 4'd0);
    run_dump("reset_restart", 100, 0, 0, 1'b0, n, c);
  endtask

  task automatic test_random();
    int n, c, pct;
    logic [AW-1:0] s, e;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      s = AW'($urandom_range(DEPTH - 1));
      e = AW'($urandom_range(DEPTH - 1));
      pct = $urandom_range(100, 25);
      n = build_expected(s, e);
      pulse_start(s, e);
      halt = 1'($urandom_range(1));
      run_dump("random", pct, 0, 0, 1'b0, n, c);
      halt = 1'b1;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reject();
    test_busy_start();
    test_grant_loss();
    test_reset_mid_dump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_dump_streamer.md
Name: ram_dump_streamer

Overview:
- Reads a contiguous window of main RAM after the CPU halts and streams each byte out over a valid/ready handshake.
- It is the read-side counterpart of the program loader that fills RAM before reset release. Lab hardware and benches use it to check memory state without hierarchical peeks.
- Sits beside the CPU. It borrows the RAM read port through a request/grant pair owned by the bus arbiter.

Parameters:
- ADDR_WIDTH, 4, RAM address width (16 locations).
- DATA_WIDTH, 8, RAM word width.
- RAM_LATENCY, 1, cycles from ram_rd_en to valid ram_rd_data (1 or 2 supported).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a dump.
- start_addr  in  ADDR_WIDTH  first address to read.
- end_addr  in  ADDR_WIDTH  last address to read (inclusive).
- halt  in  1  CPU halted flag; a dump is legal only while high.
- ram_req  out  1  request ownership of the RAM read port.
- ram_gnt  in  1  arbiter grant.
- ram_rd_en  out  1  read strobe.
- ram_addr  out  ADDR_WIDTH  read address.
- ram_rd_data  in  DATA_WIDTH  read data.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_WIDTH  streamed byte.
- out_addr  out  ADDR_WIDTH  RAM address of out_data.
- out_last  out  1  high with the final byte of the window.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.
- err  out  1  one-cycle pulse: start was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - Address counter, remaining-count counter and holding register are cleared.
  - Reset mid-dump aborts immediately. No done pulse is issued.
- States and transitions:
  - IDLE: accepts start.
    - start=1 with halt=0: err=1 for one cycle; stay in IDLE.
    - start=1 with halt=1: latch start_addr; compute count = ((end_addr - start_addr) mod 2^ADDR_WIDTH) + 1; go to REQ.
    - start_addr == end_addr gives count 1.
    - end_addr < start_addr wraps through the top address to 0, e.g. 14..1 gives 4 bytes: 14, 15, 0, 1.
  - REQ: ram_req=1. Wait for ram_gnt=1, then go to READ.
  - READ: ram_rd_en=1 for exactly one cycle with ram_addr = current address. Go to WAIT.
  - WAIT: count RAM_LATENCY cycles, then capture ram_rd_data into the holding register. Go to PRESENT.
  - PRESENT:
    - out_valid=1; out_data, out_addr and out_last are held stable until the handshake.
    - The handshake completes on a cycle where out_valid && out_ready.
    - On handshake, if not last: increment the address modulo 2^ADDR_WIDTH, decrement count, return to READ (or to REQ if ram_gnt=0).
    - On handshake, if last: go to DONE.
  - DONE: done=1 for one cycle; drop ram_req; go to IDLE.
- busy=1 in every state except IDLE.
- ram_req stays 1 from REQ through PRESENT.
- ram_gnt dropping mid-dump:
  - A read in flight completes; its data is still captured.
  - The next READ is not issued until ram_gnt returns.
- out_valid never deasserts without a handshake. It is never asserted while ram_rd_en is high.
- Minimum throughput: one byte per (2 + RAM_LATENCY) cycles with out_ready held at 1.
- start while busy is ignored: no err, no restart.
- halt falling mid-dump does not abort. It is sampled only at start.
- out_last=1 only while out_valid=1 and count==1.

Test Plan:
- Basic window: RAM[15]=8'hAB, RAM[14]=8'h1F, halt=1, start 14..15, out_ready=1 -> bytes AB-free order 8'h1F (addr 14) then 8'hAB (addr 15, out_last=1); done pulses once; busy back to 0.
- Wrap-around: RAM[14..15,0..1]=8'h10,8'h11,8'h12,8'h13, start 14..1 -> four bytes in that order with out_addr 14, 15, 0, 1; out_last only on addr 1.
- Backpressure: out_ready=0 for 5 cycles on the first byte of a 0..2 dump -> out_valid, out_data and out_addr stable for all 5 cycles; no extra ram_rd_en issued; all 3 bytes delivered in order.
- Rejection:
  - start with halt=0 -> err pulses one cycle; busy, ram_req and out_valid stay 0.
  - start pulsed while busy -> ignored; the first dump completes unchanged.
- Grant loss: drop ram_gnt after the first byte of a 3-byte dump for 4 cycles -> no ram_rd_en during those cycles; the dump resumes and completes.
- Reset mid-dump: assert reset during PRESENT -> out_valid, busy and ram_req go to 0 asynchronously; no done pulse; a new start 0..0 after release returns RAM[0] correctly.
